// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit for the CPU datapath.
// Every instruction is fetched in T0..T2 and executed in T3..T7, where the
// number of execute steps depends on the opcode. The unit stops in HALT until
// clr is asserted.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  output logic        run,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        PCin,
  output logic        incPC,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONN_in,
  output logic        InPortIn,
  output logic        OutPortIn,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic [4:0]  opcode
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction classes that share an identical execute sequence.
  typedef enum logic [3:0] {
    G_LD, G_LDI, G_ST, G_ALU, G_IMM, G_MULDIV, G_UNARY, G_BR,
    G_JR, G_JAL, G_IN, G_OUT, G_MFHI, G_MFLO, G_NOP, G_HALT
  } group_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;

  state_t     state;
  group_t     grp;
  logic [2:0] exec_len;
  logic       last_step;
  logic [4:0] ir_op;
  logic [4:0] imm_op;

  // Only the opcode field steers control; the operand fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];
  assign ir_op     = ir[31:27];

  // Classify the opcode and look up how many execute steps it needs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    grp      = G_NOP;
    exec_len = 3'd1;
    imm_op   = ALU_ADD;
    case (ir_op) inside
      5'b00000:          begin grp = G_LD;     exec_len = 3'd5; end
      5'b00001:          begin grp = G_LDI;    exec_len = 3'd3; end
      5'b00010:          begin grp = G_ST;     exec_len = 3'd5; end
      [5'b00011:5'b01011]: begin grp = G_ALU;  exec_len = 3'd3; end
      [5'b01100:5'b01110]: begin grp = G_IMM;  exec_len = 3'd3; end
      5'b01111, 5'b10000: begin grp = G_MULDIV; exec_len = 3'd4; end
      5'b10001, 5'b10010: begin grp = G_UNARY;  exec_len = 3'd2; end
      5'b10011:          begin grp = G_BR;     exec_len = 3'd4; end
      5'b10100:          grp = G_JR;
      5'b10101:          begin grp = G_JAL;    exec_len = 3'd2; end
      5'b10110:          grp = G_IN;
      5'b10111:          grp = G_OUT;
      5'b11000:          grp = G_MFHI;
      5'b11001:          grp = G_MFLO;
      5'b11011:          grp = G_HALT;
      default:           grp = G_NOP;
    endcase
    case (ir_op)
      5'b01101: imm_op = ALU_AND;
      5'b01110: imm_op = ALU_OR;
      default:  imm_op = ALU_ADD;
    endcase
  end

  // Flag the final execute step of the current instruction.
  always_comb begin
    last_step = 1'b0;
    case (state)
      S_T3:    last_step = (exec_len == 3'd1);
      S_T4:    last_step = (exec_len == 3'd2);
      S_T5:    last_step = (exec_len == 3'd3);
      S_T6:    last_step = (exec_len == 3'd4);
      S_T7:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // Step sequencer: fetch, execute, then back to T0; HALT is left only via clr.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!clr) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= (grp == G_HALT) ? S_HALT : (last_step ? S_T0 : S_T4);
        S_T4:    state <= last_step ? S_T0 : S_T5;
        S_T5:    state <= last_step ? S_T0 : S_T6;
        S_T6:    state <= last_step ? S_T0 : S_T7;
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Moore control decode. Outputs are decoded from the state rather than
  // registered because the instruction only reaches ir on the edge that enters
  // T3, and the branch condition is sampled live in T6.
  always_comb begin
    {read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, MARin, MDRin, IRin,
     PCin, incPC, Yin, Zin, HIin, LOin, CONN_in, InPortIn, OutPortIn, PCout,
     MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortout} = '0;
    opcode = 5'b00000;
    run    = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; end
      S_T1: begin read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (grp)
          G_LD, G_LDI, G_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          G_ALU, G_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          G_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          G_UNARY:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          G_BR:      begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
          G_JR:      begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          G_JAL:     begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          G_IN:      begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_OUT:     begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          G_MFHI:    begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_MFLO:    begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default:   ;
        endcase
      end
      S_T4: begin
        case (grp)
          G_LD, G_LDI, G_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD; end
          G_ALU:     begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          G_IMM:     begin Cout = 1'b1; Zin = 1'b1; opcode = imm_op; end
          G_MULDIV:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op; end
          G_UNARY:   begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_BR:      begin PCout = 1'b1; Yin = 1'b1; end
          G_JAL:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default:   ;
        endcase
      end
      S_T5: begin
        case (grp)
          G_LD, G_ST:           begin ZLowOut = 1'b1; MARin = 1'b1; end
          G_LDI, G_ALU, G_IMM:  begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_MULDIV:             begin ZLowOut = 1'b1; LOin = 1'b1; end
          G_BR:      begin Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD; end
          default:   ;
        endcase
      end
      S_T6: begin
        case (grp)
          G_LD:      begin read = 1'b1; MDRin = 1'b1; end
          G_ST:      begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          G_MULDIV:  begin ZHighOut = 1'b1; HIin = 1'b1; end
          G_BR:      begin ZLowOut = con; PCin = con; end
          default:   ;
        endcase
      end
      S_T7: begin
        case (grp)
          G_LD:      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_ST:      write = 1'b1;
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A driver walks instructions through the
// sequencer and queues the expected control word for every cycle; a monitor
// pops one entry per cycle and compares it with what the DUT presents.
// Expected words come from a textual micro-program per instruction class.
module tb_control_sequencer;

  logic        clk, clr, con;
  logic [31:0] ir;
  logic        run, read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        MARin, MDRin, IRin, PCin, incPC, Yin, Zin, HIin, LOin;
  logic        CONN_in, InPortIn, OutPortIn, PCout, MDRout, ZLowOut, ZHighOut;
  logic        HIout, LOout, InPortout;
  logic [4:0]  opcode;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [33:0] vec;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  localparam string FETCH = "PCout MARin incPC|read MDRin|MDRout IRin";

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .run(run),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .incPC(incPC),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .CONN_in(CONN_in),
    .InPortIn(InPortIn), .OutPortIn(OutPortIn), .PCout(PCout),
    .MDRout(MDRout), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .opcode(opcode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Current DUT outputs packed as {opcode, run, controls}.
  function automatic logic [33:0] act_vec();
    return {opcode, run, InPortout, LOout, HIout, ZHighOut, ZLowOut, MDRout,
            PCout, OutPortIn, InPortIn, CONN_in, LOin, HIin, Zin, Yin, incPC,
            PCin, IRin, MDRin, MARin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
            write, read};
  endfunction

  function automatic int ctl_index(string t);
    case (t)
      "read": return 0;       "write": return 1;     "Gra": return 2;
      "Grb": return 3;        "Grc": return 4;       "Rin": return 5;
      "Rout": return 6;       "BAout": return 7;     "Cout": return 8;
      "MARin": return 9;      "MDRin": return 10;    "IRin": return 11;
      "PCin": return 12;      "incPC": return 13;    "Yin": return 14;
      "Zin": return 15;       "HIin": return 16;     "LOin": return 17;
      "CONN_in": return 18;   "InPortIn": return 19; "OutPortIn": return 20;
      "PCout": return 21;     "MDRout": return 22;   "ZLowOut": return 23;
      "ZHighOut": return 24;  "HIout": return 25;    "LOout": return 26;
      "InPortout": return 27;
      default: return -1;
    endcase
  endfunction

  // Turn one micro-step ("Grc Rout Zin ALU") into the expected word; run is 1.
  // ALU means opcode follows the instruction, ADD/AND/OR force a fixed code.
  function automatic logic [33:0] step_vec(string s, logic [4:0] op);
    logic [33:0] v;
    string tok;
    int idx;
    v = '0;
    v[28] = 1'b1;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (tok.len() > 0) begin
          if (tok == "ALU")      v[33:29] = op;
          else if (tok == "ADD") v[33:29] = 5'b00011;
          else if (tok == "AND") v[33:29] = 5'b01010;
          else if (tok == "OR")  v[33:29] = 5'b01011;
          else begin
            idx = ctl_index(tok);
            if (idx >= 0) v[idx] = 1'b1;
          end
        end
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return v;
  endfunction

  // Execute micro-program per instruction, steps separated by '|'.
  function automatic string exec_prog(logic [4:0] op, bit c);
    if (op == 5'd0)  return "Grb BAout Yin|Cout Zin ADD|ZLowOut MARin|read MDRin|MDRout Gra Rin";
    if (op == 5'd1)  return "Grb BAout Yin|Cout Zin ADD|ZLowOut Gra Rin";
    if (op == 5'd2)  return "Grb BAout Yin|Cout Zin ADD|ZLowOut MARin|Gra Rout MDRin|write";
    if (op >= 5'd3 && op <= 5'd11) return "Grb Rout Yin|Grc Rout Zin ALU|ZLowOut Gra Rin";
    if (op == 5'd12) return "Grb Rout Yin|Cout Zin ADD|ZLowOut Gra Rin";
    if (op == 5'd13) return "Grb Rout Yin|Cout Zin AND|ZLowOut Gra Rin";
    if (op == 5'd14) return "Grb Rout Yin|Cout Zin OR|ZLowOut Gra Rin";
    if (op == 5'd15 || op == 5'd16) return "Gra Rout Yin|Grb Rout Zin ALU|ZLowOut LOin|ZHighOut HIin";
    if (op == 5'd17 || op == 5'd18) return "Grb Rout Zin ALU|ZLowOut Gra Rin";
    if (op == 5'd19) return c ? "Gra Rout CONN_in|PCout Yin|Cout Zin ADD|ZLowOut PCin"
                              : "Gra Rout CONN_in|PCout Yin|Cout Zin ADD|";
    if (op == 5'd20) return "Gra Rout PCin";
    if (op == 5'd21) return "PCout Grb Rin|Gra Rout PCin";
    if (op == 5'd22) return "InPortout Gra Rin";
    if (op == 5'd23) return "Gra Rout OutPortIn";
    if (op == 5'd24) return "HIout Gra Rin";
    if (op == 5'd25) return "LOout Gra Rin";
    return "";
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %09h expected %09h", name, act, exp);
    end
  endtask

  // Monitor: one expected word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, act_vec(), e.vec);
    end
  end

  task automatic push_exp(input logic [33:0] v, input string tag);
    exp_t e;
    e.vec = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Called mid-cycle; leaves the DUT one edge into T0.
  task automatic do_reset();
    clr = 1'b0;
    push_exp('0, "reset");
    @(posedge clk); #1;
    push_exp('0, "reset_hold");
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one instruction from T0. abort_at >= 0 pulses clr in that step.
  task automatic run_instr(input logic [31:0] instr, input bit c, input int abort_at);
    string steps[$];
    string full, cur;
    full = {FETCH, "|", exec_prog(instr[31:27], c)};
    cur = "";
    for (int i = 0; i < full.len(); i++) begin
      if (full[i] == 8'h7C) begin
        steps.push_back(cur);
        cur = "";
      end else begin
        cur = {cur, full.substr(i, i)};
      end
    end
    steps.push_back(cur);
    for (int k = 0; k < steps.size(); k++) begin
      if (k == 0) begin ir = $urandom; con = 1'($urandom); end
      if (k == 3) ir = instr;
      if (k == 4) con = c;
      push_exp(step_vec(steps[k], instr[31:27]),
               $sformatf("op=%b con=%0d T%0d", instr[31:27], c, k));
      if (k == abort_at) begin
        @(negedge clk); #1;
        clr = 1'b0;
        #1;
        check("async_clear", act_vec(), '0);
        @(posedge clk); #1;
        push_exp('0, "reset_mid");
        clr = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    logic [31:0] r;
    do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
    r = $urandom;
    return {op, r[26:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr = 1'b0;
    ir  = '0;
    con = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(32'h18918000, 1'b0, -1);                // add R1,R2,R3
    run_instr(32'h00800055, 1'b0, -1);                // ld
    run_instr({5'b00010, 27'h0800055}, 1'b1, -1);     // st
    run_instr({5'b10011, 27'h0880010}, 1'b1, -1);     // branch taken
    run_instr({5'b10011, 27'h0880010}, 1'b0, -1);     // branch not taken
    run_instr({5'b01111, 27'h0900000}, 1'b0, -1);     // mul
    run_instr({5'b01110, 27'h0900007}, 1'b0, -1);     // ori
    repeat (60) run_instr(rand_instr(), 1'($urandom), -1);

    run_instr({5'b11011, 27'h0}, 1'b0, -1);           // halt
    repeat (20) begin
      ir  = $urandom;
      con = 1'($urandom);
      push_exp('0, "halted");
      @(posedge clk); #1;
    end
    do_reset();

    run_instr(32'h18918000, 1'b0, 4);                 // add, clr pulsed in T4
    run_instr(32'h18918000, 1'b0, -1);
    repeat (10) run_instr(rand_instr(), 1'($urandom), -1);

    @(negedge clk); #1;
    check("queue_drained", 34'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
